// File: rtl/pll_dyn_cfg_ctrl_if.sv
// Configuration request channel between a requester and the PLL dynamic-divider sequencer.
// The requester presents a divider set with a valid/ready handshake and sees done/error pulses.
interface pll_dyn_cfg_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_idiv;
  logic [5:0] cfg_fbdiv;
  logic [5:0] cfg_odsel;
  logic       cfg_done;
  logic       cfg_error;

  modport master (
    output cfg_valid,
    output cfg_idiv,
    output cfg_fbdiv,
    output cfg_odsel,
    input  cfg_ready,
    input  cfg_done,
    input  cfg_error
  );

  modport slave (
    input  cfg_valid,
    input  cfg_idiv,
    input  cfg_fbdiv,
    input  cfg_odsel,
    output cfg_ready,
    output cfg_done,
    output cfg_error
  );
endinterface

// File: rtl/pll_dyn_cfg_ctrl.sv
// rPLL dynamic-divider sequencer: applies divider sets, qualifies LOCK with retry and fallback,
// holds sys_rst until the PLL output is stable and re-locks on lock loss.
module pll_dyn_cfg_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [5:0]  INIT_IDIV    = 6'd7,
  parameter logic [5:0]  INIT_FBDIV   = 6'd36,
  parameter logic [5:0]  INIT_ODSEL   = 6'd60
) (
  input  logic                     clk,
  input  logic                     rst,
  pll_dyn_cfg_ctrl_if.slave        cfg,
  input  logic                     pll_lock,
  output logic                     pll_reset,
  output logic [5:0]               pll_idsel,
  output logic [5:0]               pll_fbdsel,
  output logic [5:0]               pll_odsel,
  output logic                     sys_rst,
  output logic                     lock_lost
);

  localparam int unsigned CntMax = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned StbW   = $clog2(LOCK_STABLE + 1);
  localparam int unsigned RtyW   = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {StPrst, StWait, StRun} state_e;

  typedef struct packed {
    logic [5:0] idiv;
    logic [5:0] fbdiv;
    logic [5:0] odsel;
  } pll_cfg_t;

  localparam pll_cfg_t InitCfg = '{idiv: INIT_IDIV, fbdiv: INIT_FBDIV, odsel: INIT_ODSEL};

  state_e          state_q, state_d;
  pll_cfg_t        act_q, act_d, good_q, good_d;
  logic            req_q, req_d;
  logic [RtyW-1:0] retry_q, retry_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [StbW-1:0] stable_q, stable_d;
  logic            low_q, low_d;
  logic            lock_meta_q, lock_s_q;
  logic            done_q, done_d, error_q, error_d, lost_q, lost_d;
  logic            accept;

  assign accept = cfg.cfg_valid && (state_q == StRun);

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    good_d   = good_q;
    req_d    = req_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q + CntW'(1);
    stable_d = '0;
    low_d    = 1'b0;
    done_d   = 1'b0;
    error_d  = 1'b0;
    lost_d   = 1'b0;

    unique case (state_q)
      StPrst: begin
        if (cnt_q == CntW'(RST_CYCLES - 1)) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        stable_d = lock_s_q ? stable_q + StbW'(1) : '0;
        // Lock qualification is checked first so it wins over a coincident timeout.
        if (lock_s_q && (stable_q == StbW'(LOCK_STABLE - 1))) begin
          state_d  = StRun;
          cnt_d    = '0;
          stable_d = '0;
          retry_d  = '0;
          if (req_q) begin
            done_d = 1'b1;
            good_d = act_q;
            req_d  = 1'b0;
          end
        end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
          state_d  = StPrst;
          cnt_d    = '0;
          stable_d = '0;
          if (retry_q < RtyW'(MAX_RETRY)) begin
            retry_d = retry_q + RtyW'(1);
          end else begin
            // Out of attempts: a new request falls back; the good set itself just keeps trying.
            retry_d = '0;
            if (req_q) begin
              error_d = 1'b1;
              act_d   = good_q;
              req_d   = 1'b0;
            end
          end
        end
      end
      StRun: begin
        cnt_d = '0;
        low_d = ~lock_s_q;
        if (!lock_s_q && low_q) begin
          lost_d  = 1'b1;
          state_d = StPrst;
          retry_d = '0;
          req_d   = 1'b0;
        end
        if (accept) begin
          act_d   = '{idiv: cfg.cfg_idiv, fbdiv: cfg.cfg_fbdiv, odsel: cfg.cfg_odsel};
          req_d   = 1'b1;
          retry_d = '0;
          state_d = StPrst;
        end
      end
      default: begin
        state_d = StPrst;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPrst;
      act_q       <= InitCfg;
      good_q      <= InitCfg;
      req_q       <= 1'b0;
      retry_q     <= '0;
      cnt_q       <= '0;
      stable_q    <= '0;
      low_q       <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      good_q      <= good_d;
      req_q       <= req_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      low_q       <= low_d;
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      done_q      <= done_d;
      error_q     <= error_d;
      lost_q      <= lost_d;
    end
  end

  // IDSEL/FBDSEL pins take the inverted divider value; ODSEL takes the raw table code.
  assign pll_idsel     = ~act_q.idiv;
  assign pll_fbdsel    = ~act_q.fbdiv;
  assign pll_odsel     = act_q.odsel;
  assign pll_reset     = (state_q == StPrst);
  assign sys_rst       = (state_q != StRun);
  assign cfg.cfg_ready = (state_q == StRun);
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_error = error_q;
  assign lock_lost     = lost_q;

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Bench for pll_dyn_cfg_ctrl: directed scenarios plus randomized lock/request traffic, every
// cycle compared against a timestamp-based behavioural model of the sequencing rules.
module tb_pll_dyn_cfg_ctrl;
  localparam int RstCycles   = 4;
  localparam int LockStable  = 8;
  localparam int LockTimeout = 64;
  localparam int MaxRetry    = 2;
  localparam logic [5:0] InitIdiv  = 6'd7;
  localparam logic [5:0] InitFbdiv = 6'd36;
  localparam logic [5:0] InitOdsel = 6'd60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       pll_reset, sys_rst, lock_lost;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;

  pll_dyn_cfg_ctrl_if cfg_if ();

  pll_dyn_cfg_ctrl #(
    .RST_CYCLES  (RstCycles),
    .LOCK_STABLE (LockStable),
    .LOCK_TIMEOUT(LockTimeout),
    .MAX_RETRY   (MaxRetry),
    .INIT_IDIV   (InitIdiv),
    .INIT_FBDIV  (InitFbdiv),
    .INIT_ODSEL  (InitOdsel)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg       (cfg_if),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .pll_idsel (pll_idsel),
    .pll_fbdsel(pll_fbdsel),
    .pll_odsel (pll_odsel),
    .sys_rst   (sys_rst),
    .lock_lost (lock_lost)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: attempt age since reset start, consecutive-lock counters, config registers.
  bit         m_ok = 1'b0;
  bit         m_run, m_req, m_done, m_err, m_lost;
  int         m_age, m_hi, m_lo, m_tries;
  logic [5:0] m_act[3];
  logic [5:0] m_good[3];
  logic       m_hist[2];

  task automatic model_step(input logic r, input logic v, input logic [5:0] i, input logic [5:0] f,
                            input logic [5:0] o, input logic l);
    logic ls;
    ls = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = l;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_lost = 1'b0;
    if (r) begin
      m_ok = 1'b1; m_run = 1'b0; m_req = 1'b0;
      m_age = 0; m_hi = 0; m_lo = 0; m_tries = 0;
      m_act  = '{InitIdiv, InitFbdiv, InitOdsel};
      m_good = m_act;
      m_hist = '{1'b0, 1'b0};
    end else if (m_run) begin
      if (!ls && m_lo > 0) m_lost = 1'b1;
      m_lo = ls ? 0 : m_lo + 1;
      if (v) begin
        m_act = '{i, f, o}; m_req = 1'b1; m_tries = 0;
      end else if (m_lost) begin
        m_req = 1'b0; m_tries = 0;
      end
      if (v || m_lost) begin
        m_run = 1'b0; m_age = 0;
      end
    end else if (m_age < RstCycles) begin
      m_age++;
      m_hi = 0;
    end else begin
      m_hi = ls ? m_hi + 1 : 0;
      if (m_hi == LockStable) begin
        m_run = 1'b1; m_lo = 0;
        if (m_req) begin
          m_done = 1'b1; m_good = m_act; m_req = 1'b0;
        end
      end else if (m_age - RstCycles == LockTimeout - 1) begin
        m_age = 0;
        if (m_tries < MaxRetry) m_tries++;
        else begin
          m_tries = 0;
          if (m_req) begin
            m_err = 1'b1; m_act = m_good; m_req = 1'b0;
          end
        end
      end else m_age++;
    end
  endtask

  logic       s_reset, s_sys_rst, s_ready;
  logic [5:0] s_idsel, s_fbdsel, s_odsel;
  int         cnt_done = 0, cnt_err = 0, cnt_lost = 0;

  // One clock: sample and compare at the falling edge, then drive the next inputs.
  task automatic cycle(input logic r, input logic v, input logic [5:0] i, input logic [5:0] f,
                       input logic [5:0] o, input logic l);
    logic [5:0] e_i, e_f;
    @(negedge clk);
    s_reset = pll_reset; s_sys_rst = sys_rst; s_ready = cfg_if.cfg_ready;
    s_idsel = pll_idsel; s_fbdsel = pll_fbdsel; s_odsel = pll_odsel;
    if (m_ok) begin
      e_i = ~m_act[0];
      e_f = ~m_act[1];
      check_eq("pll_reset", pll_reset, !m_run && (m_age < RstCycles));
      check_eq("sys_rst", sys_rst, !m_run);
      check_eq("cfg_ready", cfg_if.cfg_ready, m_run);
      check_eq("pll_idsel", pll_idsel, e_i);
      check_eq("pll_fbdsel", pll_fbdsel, e_f);
      check_eq("pll_odsel", pll_odsel, m_act[2]);
      check_eq("cfg_done", cfg_if.cfg_done, m_done);
      check_eq("cfg_error", cfg_if.cfg_error, m_err);
      check_eq("lock_lost", lock_lost, m_lost);
      cnt_done += int'(cfg_if.cfg_done === 1'b1);
      cnt_err  += int'(cfg_if.cfg_error === 1'b1);
      cnt_lost += int'(lock_lost === 1'b1);
    end
    rst = r;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_idiv  = i;
    cfg_if.cfg_fbdiv = f;
    cfg_if.cfg_odsel = o;
    pll_lock = l;
    model_step(r, v, i, f, o, l);
  endtask

  task automatic run_until_up(input logic l, output int n);
    n = 0;
    for (int c = 0; c < 2000; c++) begin
      cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, l);
      n++;
      if (!s_sys_rst) break;
    end
  endtask

  initial begin
    int   k, lat, e0, d0, l0, n_req;
    logic prev;
    int   rises[$];

    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_idiv  = 6'd0;
    cfg_if.cfg_fbdiv = 6'd0;
    cfg_if.cfg_odsel = 6'd0;

    // Power-up: reset pulse width, initial selects, lock-to-run latency.
    repeat (3) cycle(1'b1, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
      if (s_reset) k++;
    end
    check_eq("pwr_reset_len", k, 4);
    check_eq("pwr_idsel", s_idsel, 56);
    check_eq("pwr_fbdsel", s_fbdsel, 27);
    check_eq("pwr_odsel", s_odsel, 60);
    cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b1);
    run_until_up(1'b1, lat);
    check_eq("pwr_lock_latency", lat, 10);
    check_eq("pwr_no_done", cnt_done, 0);

    // Request that never locks: three attempts, then fallback to the power-up set.
    e0 = cnt_err; d0 = cnt_done; n_req = 0; prev = 1'b0;
    cycle(1'b0, 1'b1, 6'd5, 6'd30, 6'd62, 1'b0);
    for (int c = 0; c < 2000; c++) begin
      cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, cnt_err != e0);
      if (s_reset && !prev) begin
        rises.push_back(c);
        if (s_idsel == 6'd58 && s_fbdsel == 6'd33 && s_odsel == 6'd62) n_req++;
      end
      prev = s_reset;
      if (s_ready) break;
    end
    check_eq("retry_req_pulses", n_req, 3);
    check_eq("retry_total_pulses", rises.size(), 4);
    for (int i = 0; i + 1 < rises.size() && i < 3; i++) check_eq("retry_spacing",
                                                                   rises[i+1] - rises[i], 68);
    check_eq("retry_error", cnt_err - e0, 1);
    check_eq("retry_no_done", cnt_done - d0, 0);
    check_eq("fallback_idsel", s_idsel, 56);
    check_eq("fallback_fbdsel", s_fbdsel, 27);
    check_eq("fallback_odsel", s_odsel, 60);

    // Reconfigure to 3/20/61.
    d0 = cnt_done;
    cycle(1'b0, 1'b1, 6'd3, 6'd20, 6'd61, 1'b1);
    cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b1);
    check_eq("recfg_ready", s_ready, 0);
    check_eq("recfg_reset", s_reset, 1);
    check_eq("recfg_idsel", s_idsel, 60);
    check_eq("recfg_fbdsel", s_fbdsel, 43);
    check_eq("recfg_odsel", s_odsel, 61);
    run_until_up(1'b1, lat);
    check_eq("recfg_done", cnt_done - d0, 1);

    // One-cycle lock glitch is filtered; a three-cycle drop restarts the PLL.
    l0 = cnt_lost;
    cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
    repeat (6) cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b1);
    check_eq("glitch_no_lost", cnt_lost - l0, 0);
    check_eq("glitch_still_run", s_ready, 1);
    repeat (3) cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b1);
      if (s_reset) break;
    end
    check_eq("loss_reset", s_reset, 1);
    check_eq("loss_lost", cnt_lost - l0, 1);
    check_eq("loss_idsel", s_idsel, 60);
    check_eq("loss_odsel", s_odsel, 61);
    run_until_up(1'b1, lat);

    // Lock chatter in WAIT restarts the stable count.
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
      if (s_reset) break;
    end
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
      if (!s_reset) break;
    end
    repeat (7) cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b1);
    cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
    cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b1);
    run_until_up(1'b1, lat);
    check_eq("chatter_latency", lat, 10);

    // Reset during WAIT of a new request drops it.
    cycle(1'b0, 1'b1, 6'd9, 6'd9, 6'd9, 1'b1);
    for (int c = 0; c < 20; c++) begin
      cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b1);
      if (!s_reset) break;
    end
    e0 = cnt_err; d0 = cnt_done;
    repeat (2) cycle(1'b1, 1'b0, 6'd0, 6'd0, 6'd0, 1'b1);
    cycle(1'b0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b1);
    check_eq("midrst_idsel", s_idsel, 56);
    check_eq("midrst_fbdsel", s_fbdsel, 27);
    check_eq("midrst_odsel", s_odsel, 60);
    run_until_up(1'b1, lat);
    check_eq("midrst_no_done", cnt_done - d0, 0);
    check_eq("midrst_no_error", cnt_err - e0, 0);

    // Randomized lock segments, requests and occasional resets against the model.
    for (int seg = 0; seg < 60; seg++) begin
      int r, len;
      r = int'($urandom_range(0, 9));
      len = (r < 6) ? int'($urandom_range(10, 150)) :
            (r < 8) ? int'($urandom_range(1, 3)) :
            (r < 9) ? int'($urandom_range(100, 300)) : 20;
      for (int c = 0; c < len; c++) begin
        logic lv;
        lv = (r < 6) ? 1'b1 : (r < 9) ? 1'b0 : 1'($urandom_range(0, 1));
        cycle(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 15) == 0),
              6'($urandom), 6'($urandom), 6'($urandom), lv);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
